// File: rtl/fpga_rst_seq_pkg.sv
// Shared state encoding and 50 MHz default timings for the FPGA reset sequencer.
package fpga_rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DRAM_RST   = 3'd1,
    WAIT_CALIB = 3'd2,
    PHY_RST    = 3'd3,
    PHY_WAIT   = 3'd4,
    RUN        = 3'd5,
    ERROR      = 3'd6
  } rst_seq_state_e;

  localparam int unsigned ClkFreqHz             = 50_000_000;
  localparam int unsigned DefDramRstCycles      = 16;
  localparam int unsigned DefCalibTimeoutCycles = ClkFreqHz;        // 1 s
  localparam int unsigned DefEthRstHoldCycles   = ClkFreqHz / 100;  // 10 ms
  localparam int unsigned DefEthRstWaitCycles   = ClkFreqHz / 200;  // 5 ms

  // A state lasting N cycles loads N-1; zero-length requests still last one cycle.
  function automatic int unsigned cnt_load(int unsigned cycles);
    return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
  endfunction

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetValue}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/fpga_rst_seq.sv
// Power-up/reset sequencer: clock lock, DRAM reset and calibration, PHY reset, then SoC release.
// One shared saturating down-counter times every sequencing state; all outputs are registered.
module fpga_rst_seq
  import fpga_rst_seq_pkg::*;
#(
  parameter bit          UseDram            = 1'b1,
  parameter int unsigned DramRstCycles      = DefDramRstCycles,
  parameter int unsigned CalibTimeoutCycles = DefCalibTimeoutCycles,
  parameter int unsigned EthRstHoldCycles   = DefEthRstHoldCycles,
  parameter int unsigned EthRstWaitCycles   = DefEthRstWaitCycles,
  parameter int unsigned CntWidth           = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       dram_calib_done_i,
  input  logic       sw_rst_i,
  input  logic [1:0] boot_mode_i,
  output logic       dram_rst_o,
  output logic       eth_rst_no,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       error_o,
  output logic [2:0] state_o
);

  localparam logic [CntWidth-1:0] DramLoad  = CntWidth'(cnt_load(DramRstCycles));
  localparam logic [CntWidth-1:0] CalibLoad = CntWidth'(cnt_load(CalibTimeoutCycles));
  localparam logic [CntWidth-1:0] HoldLoad  = CntWidth'(cnt_load(EthRstHoldCycles));
  localparam logic [CntWidth-1:0] WaitLoad  = CntWidth'(cnt_load(EthRstWaitCycles));

  localparam rst_seq_state_e StartState = UseDram ? DRAM_RST : PHY_RST;

  logic lock_s;
  logic calib_s;

  rst_seq_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic       dram_rst_q, dram_rst_d;
  logic       eth_rst_n_q, eth_rst_n_d;
  logic       soc_rst_n_q, soc_rst_n_d;
  logic       error_q, error_d;
  logic [1:0] boot_mode_q, boot_mode_d;
  logic       restart;
  logic       cnt_zero;

  sync u_sync_lock (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (clk_locked_i),
    .q_o   (lock_s)
  );

  sync u_sync_calib (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (dram_calib_done_i),
    .q_o   (calib_s)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      WAIT_LOCK:  if (lock_s) state_d = StartState;
      DRAM_RST:   if (cnt_zero) state_d = WAIT_CALIB;
      WAIT_CALIB: begin
        // Calibration completing on the last timeout cycle still counts as success.
        if (calib_s) begin
          state_d = PHY_RST;
        end else if (cnt_zero) begin
          state_d = ERROR;
        end
      end
      PHY_RST:    if (cnt_zero) state_d = PHY_WAIT;
      PHY_WAIT:   if (cnt_zero) state_d = RUN;
      RUN:        state_d = RUN;
      ERROR:      state_d = ERROR;
      default:    state_d = WAIT_LOCK;
    endcase

    if (state_q != WAIT_LOCK) begin
      if (!lock_s) begin
        state_d = WAIT_LOCK;
      end else if (sw_rst_i) begin
        state_d = StartState;
        restart = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_zero ? cnt_q : cnt_q - CntWidth'(1);
    // Holding sw_rst_i keeps reloading, so the start state runs its full length after release.
    if (restart || (state_d != state_q)) begin
      case (state_d)
        DRAM_RST:   cnt_d = DramLoad;
        WAIT_CALIB: cnt_d = CalibLoad;
        PHY_RST:    cnt_d = HoldLoad;
        PHY_WAIT:   cnt_d = WaitLoad;
        default:    cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    dram_rst_d  = !UseDram || (state_d inside {WAIT_LOCK, DRAM_RST, ERROR});
    eth_rst_n_d = state_d inside {PHY_WAIT, RUN};
    soc_rst_n_d = (state_d == RUN);
    error_d     = (state_d == ERROR);
    boot_mode_d = boot_mode_q;
    if (state_d == WAIT_LOCK) begin
      boot_mode_d = '0;
    end else if ((state_d == RUN) && (state_q != RUN)) begin
      boot_mode_d = boot_mode_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      dram_rst_q  <= 1'b1;
      eth_rst_n_q <= 1'b0;
      soc_rst_n_q <= 1'b0;
      error_q     <= 1'b0;
      boot_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dram_rst_q  <= dram_rst_d;
      eth_rst_n_q <= eth_rst_n_d;
      soc_rst_n_q <= soc_rst_n_d;
      error_q     <= error_d;
      boot_mode_q <= boot_mode_d;
    end
  end

  assign dram_rst_o  = dram_rst_q;
  assign eth_rst_no  = eth_rst_n_q;
  assign soc_rst_no  = soc_rst_n_q;
  assign error_o     = error_q;
  assign boot_mode_o = boot_mode_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Scoreboard bench for fpga_rst_seq: expected state transitions (with dwell times and outputs)
// are queued by the stimulus and checked by a monitor whenever state_o changes.
module tb_fpga_rst_seq;
  import fpga_rst_seq_pkg::*;

  localparam int D  = 4;
  localparam int CT = 100;
  localparam int H  = 10;
  localparam int W  = 20;
  localparam logic [5:0] RstOuts = 6'b100000;  // {dram_rst, eth_rst_n, soc_rst_n, error, boot_mode}

  typedef struct {
    logic [2:0] st;
    logic [5:0] outs;
    int         dwell;
  } exp_t;

  logic       clk;
  logic       rst_v [2];
  logic       lock, calib, sw;
  logic [1:0] bm_i;
  logic       dr_o [2];
  logic       en_o [2];
  logic       sn_o [2];
  logic       er_o [2];
  logic [1:0] bm_o [2];
  logic [2:0] st_o [2];

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       cur [2];
  logic [2:0] prev [2];
  int         dw [2];
  logic [1:0] bm_m [2];
  int         checks = 0;
  int         errors = 0;

  fpga_rst_seq #(
    .UseDram(1'b1), .DramRstCycles(D), .CalibTimeoutCycles(CT),
    .EthRstHoldCycles(H), .EthRstWaitCycles(W), .CntWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_v[0]), .clk_locked_i(lock), .dram_calib_done_i(calib),
    .sw_rst_i(sw), .boot_mode_i(bm_i), .dram_rst_o(dr_o[0]), .eth_rst_no(en_o[0]),
    .soc_rst_no(sn_o[0]), .boot_mode_o(bm_o[0]), .error_o(er_o[0]), .state_o(st_o[0])
  );

  fpga_rst_seq #(
    .UseDram(1'b0), .DramRstCycles(D), .CalibTimeoutCycles(CT),
    .EthRstHoldCycles(H), .EthRstWaitCycles(W), .CntWidth(8)
  ) dut_nd (
    .clk_i(clk), .rst_i(rst_v[1]), .clk_locked_i(lock), .dram_calib_done_i(calib),
    .sw_rst_i(sw), .boot_mode_i(bm_i), .dram_rst_o(dr_o[1]), .eth_rst_no(en_o[1]),
    .soc_rst_no(sn_o[1]), .boot_mode_o(bm_o[1]), .error_o(er_o[1]), .state_o(st_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs_of(input int g);
    return {dr_o[g], en_o[g], sn_o[g], er_o[g], bm_o[g]};
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: outputs follow from the state entered and the boot mode latched at RUN entry.
  task automatic push(input int g, input logic [2:0] st, input int dwell);
    exp_t e;
    logic dram;
    if (st == RUN) bm_m[g] = bm_i;
    else if (st == WAIT_LOCK) bm_m[g] = 2'b00;
    dram = (g == 1) || (st == WAIT_LOCK) || (st == DRAM_RST) || (st == ERROR);
    e.st    = st;
    e.dwell = dwell;
    e.outs  = {dram, (st == PHY_WAIT) || (st == RUN), st == RUN, st == ERROR, bm_m[g]};
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_tail0(input int calib_dwell);
    push(0, PHY_RST, calib_dwell);
    push(0, PHY_WAIT, H);
    push(0, RUN, W);
  endtask

  // Calib driven before edge c is seen at edge c+2; WAIT_CALIB is entered at edge 3+D after release.
  task automatic push_calib0(input int c);
    int t;
    t = c + 2 - (3 + D);
    if (t <= CT) push_tail0((t < 1) ? 1 : t);
    else push(0, ERROR, CT);
  endtask

  task automatic do_reset(input int g);
    rst_v[g] = 1'b1;
    #1;
    chk("rst_state", int'(st_o[g]), int'(WAIT_LOCK));
    chk("rst_outs", int'(outs_of(g)), int'(RstOuts));
    bm_m[g] = 2'b00;
    if (g == 0) q0.delete();
    else q1.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_empty(input int g, input int budget, input bit jiggle);
    int n;
    n = 0;
    while (qsize(g) != 0 && n < budget) begin
      @(negedge clk);
      if (jiggle) calib = 1'($urandom);
      n++;
    end
    if (qsize(g) != 0) begin
      chk("queue_drain_timeout", qsize(g), 0);
      if (g == 0) q0.delete();
      else q1.delete();
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int g = 0; g < 2; g++) begin
      if (rst_v[g]) begin
        prev[g] = WAIT_LOCK;
        dw[g]   = 0;
        cur[g]  = '{st: WAIT_LOCK, outs: RstOuts, dwell: -1};
      end else if (st_o[g] != prev[g]) begin
        if (qsize(g) == 0) begin
          chk("unexpected_transition", int'(st_o[g]), int'(prev[g]));
          cur[g].st   = st_o[g];
          cur[g].outs = outs_of(g);
        end else begin
          if (g == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("state", int'(st_o[g]), int'(e.st));
          chk("entry_outs", int'(outs_of(g)), int'(e.outs));
          if (e.dwell >= 0) chk("dwell", dw[g], e.dwell);
          cur[g] = e;
        end
        prev[g] = st_o[g];
        dw[g]   = 1;
      end else begin
        dw[g]++;
        chk("hold_outs", int'(outs_of(g)), int'(cur[g].outs));
      end
    end
  end

  initial begin
    int c, h, k;
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    lock = 1'b1; calib = 1'b0; sw = 1'b0; bm_i = 2'b10;
    bm_m[0] = 2'b00; bm_m[1] = 2'b00;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("init_state", int'(st_o[g]), int'(WAIT_LOCK));
      chk("init_outs", int'(outs_of(g)), int'(RstOuts));
    end

    // Nominal boot with calib rising at a random point
    c = int'($urandom_range(0, 14));
    calib = (c <= 1);
    push(0, DRAM_RST, -1);
    push(0, WAIT_CALIB, D);
    push_calib0(c);
    @(negedge clk); rst_v[0] = 1'b0;
    for (int i = 1; i < c; i++) @(negedge clk);
    calib = 1'b1;
    wait_empty(0, 300, 1'b0);
    repeat (6) begin
      @(negedge clk);
      bm_i = 2'($urandom);
    end

    // Calibration timeout, then soft reset recovery
    do_reset(0);
    calib = 1'b0;
    bm_i  = 2'($urandom);
    push(0, DRAM_RST, -1);
    push(0, WAIT_CALIB, D);
    push(0, ERROR, CT);
    @(negedge clk); rst_v[0] = 1'b0;
    wait_empty(0, 300, 1'b0);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    chk("error_sticky", int'(er_o[0]), 1);
    h = int'($urandom_range(1, 3));
    push(0, DRAM_RST, -1);
    push(0, WAIT_CALIB, h + D - 1);
    push_tail0(1);
    sw = 1'b1; calib = 1'b1;
    repeat (h) @(negedge clk);
    sw = 1'b0;
    wait_empty(0, 300, 1'b0);

    // Lock loss in RUN and full replay after restore
    repeat (2) @(negedge clk);
    push(0, WAIT_LOCK, -1);
    lock = 1'b0;
    repeat (3) @(negedge clk);
    chk("lockloss_state", int'(st_o[0]), int'(WAIT_LOCK));
    chk("lockloss_outs", int'(outs_of(0)), int'(RstOuts));
    k = int'($urandom_range(3, 8));
    push(0, DRAM_RST, k);
    push(0, WAIT_CALIB, D);
    push_tail0(1);
    repeat (k - 3) @(negedge clk);
    lock = 1'b1;
    wait_empty(0, 300, 1'b0);

    // Calib rise around the timeout boundary (first pass exactly coincident)
    for (int r = 0; r < 2; r++) begin
      do_reset(0);
      calib = 1'b0;
      c = (r == 0) ? (3 + D + CT - 2) : int'($urandom_range(3 + D + CT - 3, 3 + D + CT - 1));
      push(0, DRAM_RST, -1);
      push(0, WAIT_CALIB, D);
      push_calib0(c);
      @(negedge clk); rst_v[0] = 1'b0;
      for (int i = 1; i < c; i++) @(negedge clk);
      calib = 1'b1;
      wait_empty(0, 300, 1'b0);
    end

    // Reset asserted in the fifth PHY_RST cycle restarts the hold count
    do_reset(0);
    calib = 1'b1;
    push(0, DRAM_RST, -1);
    push(0, WAIT_CALIB, D);
    push(0, PHY_RST, 1);
    @(negedge clk); rst_v[0] = 1'b0;
    wait_empty(0, 300, 1'b0);
    repeat (4) @(negedge clk);
    chk("phy_mid_eth", int'(en_o[0]), 0);
    do_reset(0);
    push(0, DRAM_RST, -1);
    push(0, WAIT_CALIB, D);
    push_tail0(1);
    @(negedge clk); rst_v[0] = 1'b0;
    wait_empty(0, 300, 1'b0);

    // DRAM-less instance: calib toggles randomly and must be ignored
    do_reset(0);
    bm_i = 2'($urandom);
    push(1, PHY_RST, -1);
    push(1, PHY_WAIT, H);
    push(1, RUN, W);
    @(negedge clk); rst_v[1] = 1'b0;
    wait_empty(1, 300, 1'b1);
    repeat (3) @(negedge clk);
    bm_i = 2'($urandom);
    h = int'($urandom_range(1, 3));
    push(1, PHY_RST, -1);
    push(1, PHY_WAIT, h + H - 1);
    push(1, RUN, W);
    sw = 1'b1;
    repeat (h) @(negedge clk);
    sw = 1'b0;
    wait_empty(1, 300, 1'b1);
    repeat (3) @(negedge clk);

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
